// File: rtl/fifo_rd_unpacker.sv
// Drains a show-ahead FIFO and splits each wide entry into RATIO narrow beats,
// least-significant slice first, on a valid/ready stream with m_last per entry.
module fifo_rd_unpacker #(
    parameter int FIFO_WIDTH = 256,
    parameter int OUT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_last,
    output logic [15:0]           words_done
);

    localparam int RATIO  = FIFO_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = $clog2(RATIO) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_n;
    logic [FIFO_WIDTH-1:0]   data_buf_q, data_buf_n;
    logic [BEAT_W-1:0]       beat_q, beat_n;
    logic [15:0]             words_q, words_n;
    logic                    hs;
    logic                    pop;

    // Handshake rule: a beat transfers on a rising edge where m_valid && m_ready;
    // m_valid, once high, stays high with stable m_data/m_last until that transfer
    // (only clr or rst_n can withdraw it).
    assign m_valid    = (state_q == SEND);
    assign m_last     = (state_q == SEND) && (beat_q == BEAT_W'(RATIO - 1));
    assign m_data     = data_buf_q[OUT_WIDTH-1:0];
    assign fifo_rd_en = pop;
    assign words_done = words_q;

    always_comb begin
        hs         = m_valid && m_ready;
        pop        = rst_n && !clr && !fifo_rd_empty &&
                     ((state_q == IDLE) || (hs && m_last));
        state_n    = state_q;
        data_buf_n = data_buf_q;
        beat_n     = beat_q;
        words_n    = words_q;
        if (clr) begin
            state_n = IDLE;
            beat_n  = '0;
        end else begin
            if (hs && m_last) begin
                words_n = words_q + 16'd1;
            end
            // A pop on the last beat reloads the buffer so entries stream with no bubble.
            if (pop) begin
                data_buf_n = fifo_rd_data;
                beat_n     = '0;
                state_n    = SEND;
            end else if (hs && m_last) begin
                state_n = IDLE;
            end else if (hs) begin
                data_buf_n = data_buf_q >> OUT_WIDTH;
                beat_n     = beat_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_buf_q <= '0;
            beat_q     <= '0;
            words_q    <= '0;
        end else begin
            state_q    <= state_n;
            data_buf_q <= data_buf_n;
            beat_q     <= beat_n;
            words_q    <= words_n;
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Bench for fifo_rd_unpacker: a queue-based show-ahead FIFO model feeds the DUT,
// and a scoreboard of expected {last, data} beats checks the output stream.
module tb_fifo_rd_unpacker;

    localparam int FW = 256;
    localparam int OW = 64;
    localparam int R  = FW / OW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_rd_en;
    logic          fifo_rd_empty;
    logic [FW-1:0] fifo_rd_data;
    logic          m_valid;
    logic [OW-1:0] m_data;
    logic          m_last;
    logic [15:0]   words_done;

    logic [FW-1:0] fifo_q[$];
    logic [OW:0]   exp_q[$];
    int            n_total = 0;
    int            n_pass = 0;
    int            pop_cnt = 0;
    int            beat_cnt = 0;
    logic [15:0]   wd_exp = 16'd0;

    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always #5 clk = ~clk;

    fifo_rd_unpacker #(.FIFO_WIDTH(FW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .words_done(words_done)
    );

    function automatic void refresh();
        fifo_rd_empty = (fifo_q.size() == 0);
        fifo_rd_data  = fifo_rd_empty ? '0 : fifo_q[0];
    endfunction

    function automatic logic [FW-1:0] rand_word();
        logic [FW-1:0] w;
        for (int k = 0; k < FW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic push(input logic [FW-1:0] w);
        fifo_q.push_back(w);
        for (int i = 0; i < R; i++) exp_q.push_back({(i == R - 1), w[i*OW +: OW]});
        refresh();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // FIFO model: samples the pop request at the edge, advances the head just after it.
    always @(posedge clk) begin
        logic do_pop;
        do_pop = fifo_rd_en;
        if (do_pop) begin
            pop_cnt++;
            n_total++;
            if (fifo_q.size() == 0) $display("FAIL pop_while_empty: rd_en=1 with size=0, required rd_en=0");
            else n_pass++;
        end
        #1;
        if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh();
    end

    // Output monitor: scoreboard on handshakes, hold check after each stalled cycle.
    always @(negedge clk) begin
        logic [OW:0] exp;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_total++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last)
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, required 1 %h %b",
                             m_valid, m_data, m_last, prev_data, prev_last);
                else n_pass++;
            end
            prev_stall = m_valid && !m_ready && !clr;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready && !clr) begin
                beat_cnt++;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL beat_unexpected: got %h, required no beat", m_data);
                end else begin
                    exp = exp_q.pop_front();
                    if ({m_last, m_data} !== exp)
                        $display("FAIL beat_data: got last=%b data=%h, required last=%b data=%h",
                                 m_last, m_data, exp[OW], exp[OW-1:0]);
                    else n_pass++;
                end
            end
        end
    end

    task automatic test_reset();
        #12;
        n_total++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0 || words_done !== 16'd0 || fifo_rd_en !== 1'b0)
            $display("FAIL reset_state: valid=%b last=%b data=%h wd=%0d rd_en=%b, required all 0",
                     m_valid, m_last, m_data, words_done, fifo_rd_en);
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single();
        logic [FW-1:0] w;
        int            pops0;
        w = {64'd4, 64'd3, 64'd2, 64'd1};
        m_ready = 1'b1;
        pops0 = pop_cnt;
        push(w);
        @(negedge clk);
        n_total++;
        if (fifo_rd_en !== 1'b1 || m_valid !== 1'b0)
            $display("FAIL single_pop: rd_en=%b valid=%b, required 1 0", fifo_rd_en, m_valid);
        else n_pass++;
        for (int i = 0; i < R; i++) begin
            tick(1);
            @(negedge clk);
            n_total++;
            if (m_valid !== 1'b1 || m_data !== OW'(i + 1) || m_last !== (i == R - 1))
                $display("FAIL single_beat%0d: valid=%b data=%h last=%b, required 1 %h %b",
                         i, m_valid, m_data, m_last, OW'(i + 1), (i == R - 1));
            else n_pass++;
        end
        tick(1);
        @(negedge clk);
        wd_exp = wd_exp + 16'd1;
        n_total++;
        if (m_valid !== 1'b0 || words_done !== wd_exp || pop_cnt - pops0 != 1)
            $display("FAIL single_end: valid=%b wd=%0d pops=%0d, required 0 %0d 1",
                     m_valid, words_done, pop_cnt - pops0, wd_exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pops0, beats0, gaps, bad_rd;
        pops0 = pop_cnt;
        beats0 = beat_cnt;
        gaps = 0;
        bad_rd = 0;
        tick(1);
        m_ready = 1'b1;
        for (int e = 0; e < 3; e++) push(rand_word());
        @(negedge clk);
        if (fifo_rd_en !== 1'b1) bad_rd++;
        for (int i = 0; i < 3 * R; i++) begin
            tick(1);
            @(negedge clk);
            if (m_valid !== 1'b1) gaps++;
            if (fifo_rd_en !== (i == R - 1 || i == 2 * R - 1)) bad_rd++;
        end
        tick(1);
        @(negedge clk);
        wd_exp = wd_exp + 16'd3;
        n_total++;
        if (gaps != 0 || bad_rd != 0)
            $display("FAIL b2b_stream: gaps=%0d rd_en_errors=%0d, required 0 0", gaps, bad_rd);
        else n_pass++;
        n_total++;
        if (pop_cnt - pops0 != 3 || beat_cnt - beats0 != 3 * R || words_done !== wd_exp ||
            fifo_q.size() != 0 || m_valid !== 1'b0)
            $display("FAIL b2b_end: pops=%0d beats=%0d wd=%0d fifo=%0d valid=%b, required 3 %0d %0d 0 0",
                     pop_cnt - pops0, beat_cnt - beats0, words_done, fifo_q.size(), m_valid, 3 * R, wd_exp);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int beats0, cyc;
        logic [3:0] pat;
        pat = 4'b1001;
        beats0 = beat_cnt;
        m_ready = 1'b0;
        push(rand_word());
        cyc = 0;
        while (beat_cnt - beats0 < R && cyc < 60) begin
            tick(1);
            m_ready = (cyc < 4) ? pat[3 - cyc] : 1'($urandom_range(0, 1));
            cyc++;
            @(negedge clk);
        end
        m_ready = 1'b1;
        tick(1);
        @(negedge clk);
        wd_exp = wd_exp + 16'd1;
        n_total++;
        if (beat_cnt - beats0 != R || words_done !== wd_exp || exp_q.size() != 0)
            $display("FAIL backpressure: beats=%0d wd=%0d pending=%0d, required %0d %0d 0",
                     beat_cnt - beats0, words_done, exp_q.size(), R, wd_exp);
        else n_pass++;
    endtask

    task automatic test_empty_mid();
        int bad;
        bad = 0;
        m_ready = 1'b1;
        push(rand_word());
        tick(R + 1);
        repeat (5) begin
            @(negedge clk);
            if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
            tick(1);
        end
        n_total++;
        if (bad != 0) $display("FAIL empty_idle: %0d busy cycles, required 0", bad);
        else n_pass++;
        push(rand_word());
        @(negedge clk);
        n_total++;
        if (fifo_rd_en !== 1'b1 || m_valid !== 1'b0)
            $display("FAIL empty_repop: rd_en=%b valid=%b, required 1 0", fifo_rd_en, m_valid);
        else n_pass++;
        tick(1);
        @(negedge clk);
        n_total++;
        if (m_valid !== 1'b1) $display("FAIL empty_latency: valid=%b, required 1", m_valid);
        else n_pass++;
        tick(R);
        @(negedge clk);
        wd_exp = wd_exp + 16'd2;
        n_total++;
        if (words_done !== wd_exp || m_valid !== 1'b0)
            $display("FAIL empty_end: wd=%0d valid=%b, required %0d 0", words_done, m_valid, wd_exp);
        else n_pass++;
    endtask

    task automatic test_clr();
        logic [FW-1:0] b;
        b = rand_word();
        m_ready = 1'b1;
        push(rand_word());
        push(b);
        tick(3);
        m_ready = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        n_total++;
        if (fifo_rd_en !== 1'b0) $display("FAIL clr_no_pop: rd_en=%b, required 0", fifo_rd_en);
        else n_pass++;
        tick(1);
        clr = 1'b0;
        m_ready = 1'b1;
        repeat (R - 2) void'(exp_q.pop_front());
        @(negedge clk);
        n_total++;
        if (m_valid !== 1'b0 || fifo_rd_en !== 1'b1 || words_done !== wd_exp)
            $display("FAIL clr_after: valid=%b rd_en=%b wd=%0d, required 0 1 %0d",
                     m_valid, fifo_rd_en, words_done, wd_exp);
        else n_pass++;
        tick(1);
        @(negedge clk);
        n_total++;
        if (m_data !== b[OW-1:0]) $display("FAIL clr_next_slice0: data=%h, required %h", m_data, b[OW-1:0]);
        else n_pass++;
        tick(R);
        @(negedge clk);
        wd_exp = wd_exp + 16'd1;
        n_total++;
        if (words_done !== wd_exp || exp_q.size() != 0)
            $display("FAIL clr_end: wd=%0d pending=%0d, required %0d 0", words_done, exp_q.size(), wd_exp);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        m_ready = 1'b1;
        push(rand_word());
        push(rand_word());
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || fifo_rd_en !== 1'b0 || words_done !== 16'd0)
            $display("FAIL areset_now: valid=%b last=%b rd_en=%b wd=%0d, required 0 0 0 0",
                     m_valid, m_last, fifo_rd_en, words_done);
        else n_pass++;
        repeat (R - 2) void'(exp_q.pop_front());
        wd_exp = 16'd0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (fifo_rd_en !== 1'b1 || m_valid !== 1'b0)
            $display("FAIL areset_resume: rd_en=%b valid=%b, required 1 0", fifo_rd_en, m_valid);
        else n_pass++;
        repeat (R + 2) @(negedge clk);
        wd_exp = wd_exp + 16'd1;
        n_total++;
        if (words_done !== wd_exp || exp_q.size() != 0 || m_valid !== 1'b0)
            $display("FAIL areset_end: wd=%0d pending=%0d valid=%b, required %0d 0 0",
                     words_done, exp_q.size(), m_valid, wd_exp);
        else n_pass++;
    endtask

    initial begin
        refresh();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_empty_mid();
        test_clr();
        test_async_reset();
        tick(2);
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d beats pending, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_rd_unpacker.md
Name: fifo_rd_unpacker

Overview:
- Drains the read port of a show-ahead synchronous FIFO (rd_data valid whenever rd_empty=0; rd_en pops at the clock edge).
- Splits each wide FIFO entry into RATIO narrow beats on a valid/ready stream, LSB slice first, with m_last on the final beat.
- Sits between the wide operand/result FIFOs and the narrow-word datapaths of the Paillier modular-arithmetic pipeline.

Parameters:
- FIFO_WIDTH, 256, width of one FIFO entry.
- OUT_WIDTH, 64, width of one output beat. FIFO_WIDTH must be an integer multiple of OUT_WIDTH.
- RATIO, FIFO_WIDTH/OUT_WIDTH, beats per entry (derived localparam, min 1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: abandons the current entry, returns to IDLE.
- fifo_rd_en  out  1  pop request to the FIFO read port.
- fifo_rd_data  in  FIFO_WIDTH  FIFO head word (show-ahead).
- fifo_rd_empty  in  1  FIFO empty flag.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  OUT_WIDTH  output beat.
- m_last  out  1  final beat of the current entry.
- words_done  out  16  count of fully emitted entries, wraps at 2^16.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, buffer=0, beat counter=0, words_done=0, m_valid=0, m_data=0, m_last=0. fifo_rd_en is gated by rst_n and is 0 whenever rst_n is low.
- Internal state: state in {IDLE, SEND}; buf[FIFO_WIDTH-1:0]; beat[$clog2(RATIO):0].
- fifo_rd_en is combinational: (rst_n && !clr && !fifo_rd_empty) && (state==IDLE || (state==SEND && m_valid && m_ready && m_last)). It is never asserted while fifo_rd_empty=1.
- Pop: on the edge where fifo_rd_en=1, fifo_rd_data is captured into buf, beat<=0, and state<=SEND. The FIFO advances on the same edge.
- IDLE: m_valid=0. If the FIFO is not empty, pop and go to SEND. Latency: FIFO non-empty to first m_valid is 1 cycle.
- SEND: m_valid=1; m_data=buf[OUT_WIDTH-1:0]; m_last=(beat==RATIO-1).
- Non-last handshake (m_valid && m_ready && !m_last): buf shifts right by OUT_WIDTH (zero fill) and beat increments.
- Last handshake: words_done increments.
  - If the FIFO is not empty in that cycle, pop in the same cycle and stay in SEND with beat=0. Back-to-back entries run with no bubble, giving full throughput of 1 beat/cycle.
  - Otherwise go to IDLE.
- Backpressure: while m_valid=1 and m_ready=0, m_data, m_last, buf and beat hold stable. m_valid never drops without a handshake, except on clr or reset.
- RATIO=1: every beat is last; behaves as a pass-through register stage.
- clr (synchronous, priority over everything except rst_n): state<=IDLE, m_valid<=0, beat<=0, no pop in that cycle. The partially sent entry is discarded and words_done is unchanged.
- Reset mid-entry: the same as clr, but asynchronous, and words_done also clears. FIFO contents are untouched, since the FIFO has no reset.
- m_data, m_last and m_valid are driven from registers and state, not from fifo_rd_data directly.

Test Plan:
- Single entry: push 256'h0004_..._0003_..._0002_..._0001 (64-bit slices 1,2,3,4), m_ready=1 -> m_valid is high 1 cycle after not-empty; beats 1,2,3,4 on consecutive cycles; m_last on the 4th beat only; words_done=1; fifo_rd_en pulses exactly once.
- Back-to-back: 3 entries preloaded, m_ready=1 -> 12 consecutive beats with no gap; fifo_rd_en high on cycle 0, then on each m_last handshake cycle (3 pulses total); words_done=3; the FIFO ends empty with no pop while empty.
- Backpressure: m_ready toggles 1,0,0,1,... during one entry -> m_data is held stable while stalled; all 4 beats arrive in order exactly once.
- Empty mid-stream: the FIFO becomes empty after entry 1 -> the block returns to IDLE after m_last; fifo_rd_en stays 0. A new push 5 cycles later -> m_valid rises 1 cycle after not-empty.
- clr at beat 2 of entry A (entries A,B queued) -> m_valid is 0 the next cycle; the next beats are B's slices starting from slice 0; words_done is unchanged by A.
- Async reset mid-entry (rst_n low for 3 cycles, not clock-aligned) -> m_valid, m_last and fifo_rd_en go to 0 immediately; words_done=0; after release the block resumes with the FIFO's current head entry.
